audio_player: RTL and testbench

AUDIO_PLAYER -- requirements
Module: audio_player

---
 rtl/audio_player.sv | 128 ++++++++++++
 tb/tb_audio_player.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_player.sv
// Ping-pong RAM audio player: a sample-rate tick fetches one sample per period
// from the active buffer and feeds a first-order PDM modulator.
//
// state | meaning
// IDLE  | waiting for a sample tick; underrun handled here
// FETCH | ram_re asserted, address = play pointer
// WAIT  | synchronous RAM output settling
// LATCH | sample captured, pointer advanced, buf_done on last address
module audio_player #(
  parameter int DATA_WIDTH           = 16,
  parameter int SYS_CLK_FREQ_MHZ     = 100,
  parameter int SAMPLING_CLK_FREQ_HZ = 44100
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  EN,
  input  logic                  ping_ready,
  input  logic                  pong_ready,
  input  logic [DATA_WIDTH-1:0] ping_data_o,
  input  logic [DATA_WIDTH-1:0] pong_data_o,
  output logic [10:0]           ram_addr,
  output logic                  ram_re,
  output logic                  buf_sel,
  output logic                  buf_done,
  output logic                  buf_done_id,
  output logic [7:0]            underrun_cnt,
  output logic                  audio_pwm,
  output logic                  audio_sd
);

  localparam int DIV   = (SYS_CLK_FREQ_MHZ * 1000000) / SAMPLING_CLK_FREQ_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [DATA_WIDTH-1:0] SILENCE  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OFFSET   = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, LATCH} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [11:0]           ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] sample_u_q, sample_u_d;
  logic [7:0]            urun_q, urun_d;
  logic [DATA_WIDTH:0]   acc_q, acc_d;
  logic                  en_q;

  logic                  tick;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_data;

  assign tick      = EN && (cnt_q == CNT_LAST);
  assign sel_ready = ptr_q[11] ? pong_ready : ping_ready;
  assign sel_data  = ptr_q[11] ? pong_data_o : ping_data_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    sample_u_d = sample_u_q;
    urun_d     = urun_q;
    acc_d      = acc_q;
    ram_re     = 1'b0;
    buf_done   = 1'b0;
    if (!EN) begin
      // Dropping EN aborts any fetch in flight: nothing is latched or advanced.
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      acc_d = {1'b0, acc_q[DATA_WIDTH-1:0]} + {1'b0, sample_u_q};
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            if (sel_ready) begin
              state_d = FETCH;
            end else begin
              sample_u_d = SILENCE;
              if (urun_q != 8'hFF) urun_d = urun_q + 8'd1;
            end
          end
        end
        FETCH: begin
          ram_re  = 1'b1;
          state_d = WAIT;
        end
        WAIT: state_d = LATCH;
        LATCH: begin
          // Adding 0x7FFF undoes the sampler's offset; the 12-bit pointer
          // rollover carries into ptr[11] to swap buffers.
          sample_u_d = sel_data + OFFSET;
          ptr_d      = ptr_q + 12'd1;
          buf_done   = (ptr_q[10:0] == 11'h7FF);
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      sample_u_q <= SILENCE;
      urun_q     <= '0;
      acc_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      sample_u_q <= sample_u_d;
      urun_q     <= urun_d;
      acc_q      <= acc_d;
      en_q       <= EN;
    end
  end

  assign ram_addr     = ptr_q[10:0];
  assign buf_sel      = ptr_q[11];
  assign buf_done_id  = buf_done & ptr_q[11];
  assign underrun_cnt = urun_q;
  assign audio_pwm    = acc_q[DATA_WIDTH];
  assign audio_sd     = en_q;

endmodule

// File: tb/tb_audio_player.sv
// Bench for audio_player: randomized buffer contents, RAM model, and a
// position/sample/underrun reference kept as plain integers.
module tb_audio_player;

  localparam int SYS_MHZ  = 1;
  localparam int SAMP_HZ  = 125000;
  localparam int DIV      = (SYS_MHZ * 1000000) / SAMP_HZ;
  localparam int DEF_DIV  = (100 * 1000000) / 44100;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        EN;
  logic        ping_ready, pong_ready;
  logic [15:0] ping_rd, pong_rd;
  logic [10:0] ram_addr;
  logic        ram_re, buf_sel, buf_done, buf_done_id;
  logic [7:0]  underrun_cnt;
  logic        audio_pwm, audio_sd;

  logic        en_def;
  logic        rdy_def;
  logic [15:0] data_def;
  logic [10:0] def_addr;
  logic        def_re, def_sel, def_done, def_id, def_pwm, def_sd;
  logic [7:0]  def_urun;

  logic [15:0] ping_mem [2048];
  logic [15:0] pong_mem [2048];

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int fetches_seen = 0;
  int pwm_ones = 0;
  int last_fetch_cyc = -1;
  int exp_ptr = 0;
  logic [15:0] exp_sample = 16'h8000;
  int f0, c1, n;

  always #5 HCLK = ~HCLK;

  audio_player #(.DATA_WIDTH(16), .SYS_CLK_FREQ_MHZ(SYS_MHZ), .SAMPLING_CLK_FREQ_HZ(SAMP_HZ)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .EN(EN),
    .ping_ready(ping_ready), .pong_ready(pong_ready),
    .ping_data_o(ping_rd), .pong_data_o(pong_rd),
    .ram_addr(ram_addr), .ram_re(ram_re), .buf_sel(buf_sel),
    .buf_done(buf_done), .buf_done_id(buf_done_id),
    .underrun_cnt(underrun_cnt), .audio_pwm(audio_pwm), .audio_sd(audio_sd)
  );

  audio_player dut_def (
    .HCLK(HCLK), .HRESETn(HRESETn), .EN(en_def),
    .ping_ready(rdy_def), .pong_ready(rdy_def),
    .ping_data_o(data_def), .pong_data_o(data_def),
    .ram_addr(def_addr), .ram_re(def_re), .buf_sel(def_sel),
    .buf_done(def_done), .buf_done_id(def_id),
    .underrun_cnt(def_urun), .audio_pwm(def_pwm), .audio_sd(def_sd)
  );

  // Synchronous RAM: data valid one clock after the read strobe, then held.
  always @(posedge HCLK) begin
    if (ram_re) begin
      ping_rd <= ping_mem[ram_addr];
      pong_rd <= pong_mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
    cyc_n++;
    if (ram_re) fetches_seen++;
    if (audio_pwm) pwm_ones++;
  endtask

  function automatic logic [15:0] mem_at(input int p);
    return (p < 2048) ? ping_mem[p] : pong_mem[p - 2048];
  endfunction

  task automatic wait_fetch();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!ram_re && k < 4 * DIV);
    check("fetch_seen", ram_re, 1);
  endtask

  task automatic play_tick();
    wait_fetch();
    check("fetch_pos", {buf_sel, ram_addr}, exp_ptr);
    if (last_fetch_cyc >= 0) check("tick_spacing", cyc_n - last_fetch_cyc, DIV);
    last_fetch_cyc = cyc_n;
    cyc();
    check("wait_no_re", ram_re, 0);
    cyc();
    check("buf_done", buf_done, (exp_ptr % 2048) == 2047);
    if ((exp_ptr % 2048) == 2047) check("buf_done_id", buf_done_id, exp_ptr / 2048);
    exp_sample = mem_at(exp_ptr) + 16'h7FFF;
    exp_ptr = (exp_ptr + 1) % 4096;
    cyc();
    check("sample_u", dut.sample_u_q, exp_sample);
    check("pos_next", {buf_sel, ram_addr}, exp_ptr);
    check("buf_done_pulse", buf_done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_re"}, ram_re, 0);
    check({tag, "_done"}, buf_done, 0);
    check({tag, "_id"}, buf_done_id, 0);
    check({tag, "_pwm"}, audio_pwm, 0);
    check({tag, "_sd"}, audio_sd, 0);
    check({tag, "_pos"}, {buf_sel, ram_addr}, 0);
    check({tag, "_urun"}, underrun_cnt, 0);
    check({tag, "_sample"}, dut.sample_u_q, 16'h8000);
  endtask

  initial begin
    HRESETn = 1'b0; EN = 1'b0; ping_ready = 1'b0; pong_ready = 1'b0;
    en_def = 1'b0; rdy_def = 1'b1; data_def = 16'h0000;
    for (int i = 0; i < 2048; i++) begin
      ping_mem[i] = 16'($urandom);
      pong_mem[i] = 16'($urandom);
    end
    for (int i = 6; i <= 40; i++) ping_mem[i] = 16'h4001;

    repeat (3) cyc();
    check_reset_outputs("reset");
    HRESETn = 1'b1;
    cyc();

    // First tick arrives DIV cycles after EN rises; play from ping 0.
    EN = 1'b1; en_def = 1'b1; ping_ready = 1'b1; pong_ready = 1'b1;
    last_fetch_cyc = cyc_n;
    repeat (5) play_tick();

    // EN dropped during WAIT at address 5.
    wait_fetch();
    check("abort_fetch_pos", {buf_sel, ram_addr}, exp_ptr);
    cyc();
    EN = 1'b0;
    cyc();
    cyc();
    check("abort_pos_held", {buf_sel, ram_addr}, 5);
    check("abort_no_done", buf_done, 0);
    check("abort_pwm", audio_pwm, 0);
    check("abort_sd", audio_sd, 0);
    check("abort_sample_held", dut.sample_u_q, exp_sample);
    f0 = fetches_seen;
    repeat (3 * DIV) cyc();
    check("disabled_no_fetch", fetches_seen - f0, 0);
    EN = 1'b1;
    last_fetch_cyc = cyc_n;
    play_tick();

    // Constant 0x4001 -> sample 0xC000 -> three ones in every four cycles.
    play_tick();
    pwm_ones = 0;
    f0 = fetches_seen;
    repeat (64) cyc();
    check("pdm_c000", pwm_ones, 48);
    exp_ptr = exp_ptr + (fetches_seen - f0);
    last_fetch_cyc = -1;

    // Underrun: exactly one tick per DIV cycles, counter saturates.
    play_tick();
    ping_ready = 1'b0;
    f0 = fetches_seen;
    repeat (100 * DIV) cyc();
    check("urun_100", underrun_cnt, 100);
    check("urun_silence", dut.sample_u_q, 16'h8000);
    check("urun_pos_held", {buf_sel, ram_addr}, exp_ptr);
    pwm_ones = 0;
    repeat (64) cyc();
    check("pdm_8000", pwm_ones, 32);
    repeat (200 * DIV - 64) cyc();
    check("urun_sat", underrun_cnt, 255);
    check("urun_no_fetch", fetches_seen - f0, 0);
    check("urun_pos_held2", {buf_sel, ram_addr}, exp_ptr);
    ping_ready = 1'b1;
    last_fetch_cyc = -1;
    play_tick();
    check("urun_kept", underrun_cnt, 255);

    // Play to ping 2047, then reset in the middle of its LATCH cycle.
    while (exp_ptr != 2047) play_tick();
    wait_fetch();
    check("last_fetch_pos", {buf_sel, ram_addr}, 12'h7FF);
    cyc();
    cyc();
    #2 HRESETn = 1'b0;
    #1 check_reset_outputs("mid_latch_reset");
    cyc();
    cyc();
    check_reset_outputs("held_reset");
    HRESETn = 1'b1;
    exp_ptr = 0;
    last_fetch_cyc = cyc_n;

    // Full loop: ping 0..2047, pong 0..2047, back to ping 0.
    repeat (4097) play_tick();
    check("wrap_pos", exp_ptr, {buf_sel, ram_addr});

    // Default parameters: one fetch every 2267 clocks.
    n = 0;
    do begin cyc(); n++; end while (!def_re && n < 3 * DEF_DIV);
    check("def_fetch_seen", def_re, 1);
    c1 = cyc_n;
    cyc();
    n = 0;
    do begin cyc(); n++; end while (!def_re && n < 3 * DEF_DIV);
    check("def_fetch_seen2", def_re, 1);
    check("def_tick_spacing", cyc_n - c1, DEF_DIV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
